// File: rtl/truth_table_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_scanner_pkg
// Description : Shared state encoding and sizing constants for the truth
//               table scanner and its hold timer.
// Revision    : 1.0 - initial release
// ============================================================================
package truth_table_scanner_pkg;

  // Scanner control states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int VEC_COUNT = 16;
  localparam int IDX_W     = 4;
  localparam int HOLD_W    = 8;

  // Index of the final vector; reaching it ends the scan
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);

endpackage : truth_table_scanner_pkg
`default_nettype wire

// File: rtl/truth_table_scanner_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : scan_hold_timer
// Description : 8-bit hold counter. Counts while not cleared and wraps to
//               zero after the terminal count HOLD_CYCLES-1, which is
//               flagged combinationally on tc.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_hold_timer
  import truth_table_scanner_pkg::*;
#(
  parameter int HOLD_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tc
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] count_q;
  logic [HOLD_W-1:0] count_d;

  assign tc = (count_q == HOLD_LAST);

  // Next count: restart on clear or at terminal count, else increment
  always_comb begin
    count_d = count_q + HOLD_W'(1);
    if (clear || tc) begin
      count_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : scan_hold_timer
`default_nettype wire

// File: rtl/truth_table_scanner.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_scanner
// Description : Walks all 16 vectors of a 4-input combinational block in
//               binary order, holds each HOLD_CYCLES cycles, samples q at
//               the end of each hold and builds the truth table and its
//               ones count. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int HOLD_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        q,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  ones_count
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        table_q, table_d;
  logic [4:0]         ones_q, ones_d;
  logic [3:0]         abcd_q, abcd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               hold_tc;

  // Hold counter only runs while a vector is being driven
  scan_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q != ST_DRIVE),
    .tc    (hold_tc)
  );

  // Next-state, capture and registered-output decode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    table_d = table_q;
    ones_d  = ones_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          idx_d   = '0;
          table_d = '0;
          ones_d  = '0;
        end
      end
      ST_DRIVE: begin
        if (hold_tc) begin
          table_d[idx_q] = q;
          ones_d         = ones_q + {4'b0000, q};
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Outputs follow the state being entered so they align with it
    busy_d = (state_d == ST_DRIVE);
    done_d = (state_d == ST_DONE);
    abcd_d = busy_d ? idx_d : 4'b0000;
  end

  // State and output registers, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      table_q <= '0;
      ones_q  <= '0;
      abcd_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      table_q <= table_d;
      ones_q  <= ones_d;
      abcd_q  <= abcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign {a, b, c, d}  = abcd_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign truth_table   = table_q;
  assign ones_count    = ones_q;

endmodule : truth_table_scanner
`default_nettype wire

// File: tb/tb_truth_table_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_scanner
// Description : Self-checking bench. Three scanners (H=5, 1, 3) each drive
//               their own combinational block; expected scan results are
//               queued when start is driven and compared when done fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_v [3];
  logic        q_w     [3];
  logic        a_w     [3];
  logic        b_w     [3];
  logic        c_w     [3];
  logic        d_w     [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic [15:0] tt_w    [3];
  logic [4:0]  ones_w  [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          sel;
    int          h;
    logic [15:0] tt;
    logic [4:0]  ones;
    int          p0;
    int          p1;
  } vec_t;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  ones;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[3];

  always #5 clk = ~clk;

  // Blocks under test
  assign q_w[0] = a_w[0] ^ b_w[0] ^ c_w[0] ^ d_w[0];
  assign q_w[1] = (a_w[1] & b_w[1]) | (c_w[1] & d_w[1]);
  assign q_w[2] = 1'b1;

  truth_table_scanner #(.HOLD_CYCLES(5)) u_h5 (
    .clk(clk), .rst(rst), .start(start_v[0]), .q(q_w[0]),
    .a(a_w[0]), .b(b_w[0]), .c(c_w[0]), .d(d_w[0]),
    .busy(busy_w[0]), .done(done_w[0]),
    .truth_table(tt_w[0]), .ones_count(ones_w[0])
  );

  truth_table_scanner #(.HOLD_CYCLES(1)) u_h1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .q(q_w[1]),
    .a(a_w[1]), .b(b_w[1]), .c(c_w[1]), .d(d_w[1]),
    .busy(busy_w[1]), .done(done_w[1]),
    .truth_table(tt_w[1]), .ones_count(ones_w[1])
  );

  truth_table_scanner #(.HOLD_CYCLES(3)) u_h3 (
    .clk(clk), .rst(rst), .start(start_v[2]), .q(q_w[2]),
    .a(a_w[2]), .b(b_w[2]), .c(c_w[2]), .d(d_w[2]),
    .busy(busy_w[2]), .done(done_w[2]),
    .truth_table(tt_w[2]), .ones_count(ones_w[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] abcd_of(input int s);
    return {a_w[s], b_w[s], c_w[s], d_w[s]};
  endfunction

  function automatic bit outs_zero(input int s);
    return (abcd_of(s) == 4'b0000) && !busy_w[s] && !done_w[s] &&
           (tt_w[s] == 16'h0000) && (ones_w[s] == 5'd0);
  endfunction

  // One full scan on the selected scanner with optional ignored start pulses
  task automatic run_scan(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    int   cyc;
    int   bad_busy;
    int   bad_abcd;
    int   noisy;
    bit   seen;
    @(posedge clk); #1;
    start_v[v.sel] = 1'b1;
    e.tt = v.tt; e.ones = v.ones; e.done_cyc = 16 * v.h;
    sb.push_back(e);
    @(posedge clk); #1;
    start_v[v.sel] = 1'b0;
    cyc = 0; seen = 1'b0; bad_busy = 0; bad_abcd = 0;
    while (!seen && cyc <= 16 * v.h + 20) begin
      @(negedge clk);
      start_v[v.sel] = (cyc == v.p0 || cyc == v.p1);
      if (done_w[v.sel]) begin
        seen = 1'b1;
      end else begin
        if (!busy_w[v.sel]) bad_busy++;
        if (abcd_of(v.sel) != 4'(cyc / v.h)) bad_abcd++;
        cyc++;
      end
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      if (seen) begin
        chk({tag, " done_cycle"}, 32'(cyc), 32'(got.done_cyc));
        chk({tag, " truth_table"}, 32'(tt_w[v.sel]), 32'(got.tt));
        chk({tag, " ones_count"}, 32'(ones_w[v.sel]), 32'(got.ones));
        chk({tag, " busy_at_done"}, 32'(busy_w[v.sel]), 32'd0);
      end
    end
    chk({tag, " busy_during_scan"}, 32'(bad_busy), 32'd0);
    chk({tag, " abcd_sequence"}, 32'(bad_abcd), 32'd0);
    // After DONE the scanner must sit in IDLE, even with an ignored start
    noisy = 0;
    for (int k = 0; k < 2 * v.h + 6; k++) begin
      @(negedge clk);
      start_v[v.sel] = 1'b0;
      if (done_w[v.sel] || busy_w[v.sel] || abcd_of(v.sel) != 4'b0000) noisy++;
    end
    chk({tag, " idle_after_done"}, 32'(noisy), 32'd0);
    chk({tag, " table_held"}, 32'(tt_w[v.sel]), 32'(v.tt));
  endtask

  initial begin
    exp_t got;
    int   noisy;
    int   b2b_cyc;

    tbl[0] = '{sel: 0, h: 5, tt: 16'h6996, ones: 5'd8,  p0: -1, p1: -1};
    tbl[1] = '{sel: 1, h: 1, tt: 16'hF888, ones: 5'd7,  p0: -1, p1: -1};
    tbl[2] = '{sel: 2, h: 3, tt: 16'hFFFF, ones: 5'd16, p0: 5,  p1: 48};

    for (int s = 0; s < 3; s++) start_v[s] = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) chk($sformatf("reset_outputs_%0d", s), 32'(outs_zero(s)), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Stays idle after reset release with start low
    noisy = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) if (!outs_zero(s)) noisy++;
    end
    chk("idle_after_reset", 32'(noisy), 32'd0);

    // Table-driven full scans
    for (int i = 0; i < 3; i++) run_scan(tbl[i], $sformatf("scan%0d", i));

    // Reset in the middle of vector 7 on the H=5 scanner
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    for (int k = 0; k < 38; k++) @(negedge clk);
    chk("pre_reset_vector", 32'(abcd_of(0)), 32'd7);
    rst = 1'b1;
    #1;
    chk("midscan_reset_busy", 32'(busy_w[0]), 32'd0);
    chk("midscan_reset_abcd", 32'(abcd_of(0)), 32'd0);
    chk("midscan_reset_table", 32'(tt_w[0]), 32'd0);
    chk("midscan_reset_ones", 32'(ones_w[0]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    noisy = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done_w[0] || busy_w[0]) noisy++;
    end
    chk("no_done_after_reset", 32'(noisy), 32'd0);
    run_scan(tbl[0], "rescan");

    // Back-to-back scans on the H=1 scanner with start held high
    @(posedge clk); #1;
    start_v[1] = 1'b1;
    got.tt = 16'hF888; got.ones = 5'd7;
    got.done_cyc = 16; sb.push_back(got);
    got.done_cyc = 34; sb.push_back(got);
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      b2b_cyc = k - 1;
      if (k == 0) continue;
      if (b2b_cyc == 34) start_v[1] = 1'b0;
      if (done_w[1]) begin
        if (sb.size() > 0) begin
          got = sb.pop_front();
          chk("b2b_done_cycle", 32'(b2b_cyc), 32'(got.done_cyc));
          chk("b2b_truth_table", 32'(tt_w[1]), 32'(got.tt));
          chk("b2b_ones_count", 32'(ones_w[1]), 32'(got.ones));
        end else begin
          chk("b2b_extra_done", 32'(b2b_cyc), 32'hFFFF_FFFF);
        end
      end
      if (b2b_cyc == 17) chk("b2b_idle_gap", 32'({busy_w[1], done_w[1]}), 32'd0);
      if (b2b_cyc == 18) begin
        chk("b2b_second_busy", 32'(busy_w[1]), 32'd1);
        chk("b2b_table_cleared", 32'(tt_w[1]), 32'd0);
        chk("b2b_first_vector", 32'(abcd_of(1)), 32'd0);
      end
    end
    start_v[1] = 1'b0;
    chk("b2b_missing_done", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_truth_table_scanner
`default_nettype wire

// File: doc/truth_table_scanner.md
# truth_table_scanner

Stimulus sequencer that drives a 4-input combinational block under test (inputs a, b, c, d; output q). On a start request it walks all 16 input vectors in binary order, holds each for a programmable number of clock cycles, samples q at the end of each hold, and builds the complete 16-bit truth table plus a ones count. It sits directly upstream of the combinational stage, feeding its inputs, and consumes that stage's output on the return path.

## Interface
- HOLD_CYCLES, default 5: cycles each vector is held; legal range 1..255.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  scan request; sampled only in IDLE.
- q  input  1  output of the block under test; sampled synchronously.
- a, b, c, d  output  1 each  drive to the block under test; {a,b,c,d} = vector index, with a as the MSB.
- busy  output  1  high for the full duration of a scan.
- done  output  1  single-cycle pulse when the scan completes.
- truth_table  output  16  bit k = q observed for vector k.
- ones_count  output  5  number of set bits in truth_table (0..16).

## Operation
- States:
  - IDLE: busy=0, abcd=0000. start=1 → DRIVE; on that edge, idx←0, hold←0, truth_table←0, ones_count←0.
  - DRIVE: busy=1, abcd=idx. hold increments each cycle. On the cycle where hold==HOLD_CYCLES-1:
    - truth_table[idx]←q, ones_count←ones_count+q, hold←0.
    - If idx==15 → DONE; otherwise idx←idx+1.
  - DONE: busy=0, done=1, abcd=0000 for one cycle, then → IDLE unconditionally.
- start is ignored in DRIVE and DONE; there is no queueing.
- truth_table and ones_count hold their final values until the next accepted start, which clears both.
- ones_count is 5 bits wide so that 16 does not wrap.
- idx is 4 bits; the wrap from 15 never occurs because the exit to DONE happens first.
- hold counter width is 8 bits.
- rst (asynchronous, any state including mid-scan):
  - State→IDLE; idx, hold, truth_table, ones_count→0.
  - Outputs a, b, c, d, busy, done→0 immediately.
  - A scan interrupted by reset produces no done pulse.

## Timing
- Reset values: a=b=c=d=0, busy=0, done=0, truth_table=16'h0000, ones_count=0.
- Let cycle 0 be the first cycle after the edge that accepts start. busy=1 from cycle 0.
- Vector k is driven during cycles k·H .. k·H+H-1, where H=HOLD_CYCLES.
- q is sampled on the rising edge ending cycle k·H+H-1. truth_table[k] is visible from cycle k·H+H.
- With H=1, q is sampled one cycle after each vector is applied; the block under test must settle within one cycle.
- done=1 and busy=0 in cycle 16·H; the block is in IDLE at cycle 16·H+1.
- start asserted in cycle 16·H (DONE) is ignored. start in cycle 16·H+1 is accepted.
- Start-to-done latency is 16·H+1 edges.
- q must be stable within H cycles of a vector change; no synchronizer is required because q is combinational from a, b, c, d.

## Structure
- Shared package/header holds:
  - State encoding constants ST_IDLE, ST_DRIVE, ST_DONE (2 bits).
  - VEC_COUNT=16 and IDX_W=4.
- Optional sub-module scan_hold_timer: 8-bit counter with clear input and terminal-count output at HOLD_CYCLES-1. The FSM, index register and truth-table capture stay in truth_table_scanner.
- The combinational block under test is instantiated only in the bench, never inside this block.

## Test plan
- q=a^b^c^d, H=5, single start → done pulse in cycle 80, truth_table=16'h6996, ones_count=8.
- q=(a&b)|(c&d), H=1 → done in cycle 16, truth_table=16'hF888, ones_count=7; abcd steps 0000→1111 once per cycle.
- q tied to 1, H=3 → truth_table=16'hFFFF, ones_count=16 (no wrap); start pulsed in cycles 5 and 48 → ignored, single done in cycle 48.
- rst asserted mid-cycle while vector 7 is driven, H=5 → busy, abcd, truth_table, ones_count read 0 before the next edge; no done pulse. A restart then yields the full correct table.
- Back-to-back scans: start held high continuously → scans separated by exactly one DONE cycle and one IDLE cycle; truth_table reads 0 in cycle 0 of the second scan.
- Reset-release check: outputs all 0 after reset with start=0; the block remains in IDLE indefinitely.
